// File: rtl/jtkcpu_rmw_ctl.sv
`timescale 1ns/1ps
// Purpose : sequences one read-modify-write (READ, EXEC, WRITE, DONE) around an external combinational ALU.
// Latency : done 4 cycles after start with immediate mem_ack; 3 cycles for TST/CLR; 1 cycle for an illegal op.
// Backpres: READ/WRITE strobes are held until mem_ack; WAIT_MAX cycles without ack abort with err.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, op, addr, cc_in    request; captured only in IDLE
//   busy, done, err           status; done/err are one-cycle pulses
//   mem_addr/rd/we/dout/din/ack  simple strobe/acknowledge memory bus
//   alu_op/opnd0/cc, alu_rslt/cc_out  external combinational ALU
//   cc_out, cc_we             final condition codes and their one-cycle strobe
module jtkcpu_rmw_ctl #(
    parameter int AW       = 16,
    parameter int WAIT_MAX = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    op,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    cc_in,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_we,
    output logic [7:0]    mem_dout,
    input  logic [7:0]    mem_din,
    input  logic          mem_ack,
    output logic [7:0]    alu_op,
    output logic [7:0]    alu_opnd0,
    output logic [7:0]    alu_cc,
    input  logic [7:0]    alu_rslt,
    input  logic [7:0]    alu_cc_out,
    output logic [7:0]    cc_out,
    output logic          cc_we
);

    localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    // Last count value before the abort; an unacknowledged cycle at this
    // count is the WAIT_MAX-th one.
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        EXEC  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state_q;
    logic            busy_q, done_q, err_q, cc_we_q;
    logic            mem_rd_q, mem_we_q;
    logic [AW-1:0]   mem_addr_q, addr_q;
    logic [7:0]      op_q, cc_q, data_q, rslt_q, flags_q, cc_out_q;
    logic [CW-1:0]   wait_q;

    logic            op_legal, op_clr, op_q_tst;

    assign op_legal = (op >= 8'h80) && (op <= 8'hA2);
    assign op_clr   = (op >= 8'h80) && (op <= 8'h82);
    assign op_q_tst = (op_q >= 8'h90) && (op_q <= 8'h92);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cc_we_q    <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            addr_q     <= '0;
            op_q       <= '0;
            cc_q       <= '0;
            data_q     <= '0;
            rslt_q     <= '0;
            flags_q    <= '0;
            cc_out_q   <= '0;
            wait_q     <= '0;
        end else begin
            // Pulses default low; only the transition into DONE raises them.
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cc_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        addr_q <= addr;
                        cc_q   <= cc_in;
                        busy_q <= 1'b1;
                        if (!op_legal) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (op_clr) begin
                            // CLR ignores the old operand, so skip the read.
                            data_q  <= 8'h00;
                            state_q <= EXEC;
                        end else begin
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= addr;
                            wait_q     <= '0;
                            state_q    <= READ;
                        end
                    end
                end
                READ: begin
                    if (mem_ack) begin
                        data_q   <= mem_din;
                        mem_rd_q <= 1'b0;
                        state_q  <= EXEC;
                    end else if (wait_q == WAIT_LAST) begin
                        mem_rd_q <= 1'b0;
                        done_q   <= 1'b1;
                        err_q    <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        wait_q <= wait_q + CW'(1);
                    end
                end
                EXEC: begin
                    rslt_q  <= alu_rslt;
                    flags_q <= alu_cc_out;
                    if (op_q_tst) begin
                        done_q   <= 1'b1;
                        cc_we_q  <= 1'b1;
                        cc_out_q <= alu_cc_out;
                        state_q  <= DONE;
                    end else begin
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= addr_q;
                        wait_q     <= '0;
                        state_q    <= WRITE;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_we_q <= 1'b0;
                        done_q   <= 1'b1;
                        cc_we_q  <= 1'b1;
                        cc_out_q <= flags_q;
                        state_q  <= DONE;
                    end else if (wait_q == WAIT_LAST) begin
                        mem_we_q <= 1'b0;
                        done_q   <= 1'b1;
                        err_q    <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        wait_q <= wait_q + CW'(1);
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q   <= 1'b0;
                    mem_rd_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign cc_we     = cc_we_q;
    assign cc_out    = cc_out_q;
    assign mem_rd    = mem_rd_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_dout  = rslt_q;
    assign alu_op    = op_q;
    assign alu_opnd0 = data_q;
    assign alu_cc    = cc_q;

endmodule

// File: tb/tb_jtkcpu_rmw_ctl.sv
`timescale 1ns/1ps
module tb_jtkcpu_rmw_ctl;

    localparam int AW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start_a, start_b, mem_ack_a, mem_ack_b;
    logic [7:0]    op, cc_in, mem_din;
    logic [AW-1:0] addr;

    logic          busy_a, done_a, err_a, mem_rd_a, mem_we_a, cc_we_a;
    logic [AW-1:0] mem_addr_a;
    logic [7:0]    mem_dout_a, alu_op_a, alu_opnd0_a, alu_cc_a, alu_rslt_a, alu_cc_out_a, cc_out_a;

    logic          busy_b, done_b, err_b, mem_rd_b, mem_we_b, cc_we_b;
    logic [AW-1:0] mem_addr_b;
    logic [7:0]    mem_dout_b, alu_op_b, alu_opnd0_b, alu_cc_b, alu_rslt_b, alu_cc_out_b, cc_out_b;

    // Reference ALU for the ops exercised here; returns {flags, result}.
    function automatic logic [15:0] alu_model(input logic [7:0] o, input logic [7:0] a, input logic [7:0] c);
        logic [7:0] r;
        logic [7:0] f;
        r = a;
        f = c;
        if (o >= 8'h80 && o <= 8'h82) begin
            r = 8'h00;
            f = {c[7:4], 4'b0100};
        end else if (o >= 8'h86 && o <= 8'h88) begin
            r = 8'h00 - a;
            f = {c[7:4], r[7], (r == 8'h00), (a == 8'h80), (a != 8'h00)};
        end else if (o >= 8'h89 && o <= 8'h8B) begin
            r = a + 8'h01;
            f = {c[7:4], r[7], (r == 8'h00), (a == 8'h7F), c[0]};
        end else if (o >= 8'h90 && o <= 8'h92) begin
            f = {c[7:4], a[7], (a == 8'h00), 1'b0, c[0]};
        end
        return {f, r};
    endfunction

    assign {alu_cc_out_a, alu_rslt_a} = alu_model(alu_op_a, alu_opnd0_a, alu_cc_a);
    assign {alu_cc_out_b, alu_rslt_b} = alu_model(alu_op_b, alu_opnd0_b, alu_cc_b);

    jtkcpu_rmw_ctl #(.AW(AW), .WAIT_MAX(255)) dut (
        .clk(clk), .rst(rst), .start(start_a), .op(op), .addr(addr), .cc_in(cc_in),
        .busy(busy_a), .done(done_a), .err(err_a),
        .mem_addr(mem_addr_a), .mem_rd(mem_rd_a), .mem_we(mem_we_a), .mem_dout(mem_dout_a),
        .mem_din(mem_din), .mem_ack(mem_ack_a),
        .alu_op(alu_op_a), .alu_opnd0(alu_opnd0_a), .alu_cc(alu_cc_a),
        .alu_rslt(alu_rslt_a), .alu_cc_out(alu_cc_out_a),
        .cc_out(cc_out_a), .cc_we(cc_we_a)
    );

    jtkcpu_rmw_ctl #(.AW(AW), .WAIT_MAX(4)) dut_to (
        .clk(clk), .rst(rst), .start(start_b), .op(op), .addr(addr), .cc_in(cc_in),
        .busy(busy_b), .done(done_b), .err(err_b),
        .mem_addr(mem_addr_b), .mem_rd(mem_rd_b), .mem_we(mem_we_b), .mem_dout(mem_dout_b),
        .mem_din(mem_din), .mem_ack(mem_ack_b),
        .alu_op(alu_op_b), .alu_opnd0(alu_opnd0_b), .alu_cc(alu_cc_b),
        .alu_rslt(alu_rslt_b), .alu_cc_out(alu_cc_out_b),
        .cc_out(cc_out_b), .cc_we(cc_we_b)
    );

    // Memory responder: ack after ack_delay unacknowledged strobe cycles (0 = always high).
    int ack_delay = 0;
    int wait_cnt  = 0;
    always @(posedge clk) begin
        if (rst || !(mem_rd_a || mem_we_a) || mem_ack_a) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end
    assign mem_ack_a = (ack_delay == 0) || (wait_cnt >= ack_delay);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit we; logic [AW-1:0] addr; logic [7:0] data; } bus_t;
    typedef struct { logic err; logic cc_we; logic [7:0] cc; int lat; int t0; } res_t;
    bus_t bus_q[$];
    res_t res_q[$];
    bus_t mb;
    res_t mr;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    bit we_seen_b  = 1'b0;
    int rd_cyc_b   = 0;

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rd_we_exclusive", {31'd0, mem_rd_a & mem_we_a}, 32'd0);
            if ((mem_rd_a || mem_we_a) && mem_ack_a) begin
                chk("bus_access_expected", {31'd0, bus_q.size() != 0}, 32'd1);
                if (bus_q.size() != 0) begin
                    mb = bus_q.pop_front();
                    chk("bus_kind_we", {31'd0, mem_we_a}, {31'd0, mb.we});
                    chk("bus_addr", {16'd0, mem_addr_a}, {16'd0, mb.addr});
                    if (mb.we) chk("bus_wdata", {24'd0, mem_dout_a}, {24'd0, mb.data});
                end
            end
            if (err_a || cc_we_a) chk("pulse_with_done", {31'd0, done_a}, 32'd1);
            if (done_a) begin
                chk("done_expected", {31'd0, res_q.size() != 0}, 32'd1);
                if (res_q.size() != 0) begin
                    mr = res_q.pop_front();
                    chk("res_err", {31'd0, err_a}, {31'd0, mr.err});
                    chk("res_cc_we", {31'd0, cc_we_a}, {31'd0, mr.cc_we});
                    if (mr.cc_we) chk("res_cc_out", {24'd0, cc_out_a}, {24'd0, mr.cc});
                    chk("res_latency", cyc - mr.t0, mr.lat);
                end
            end
            if (mem_we_b) we_seen_b = 1'b1;
            if (mem_rd_b) rd_cyc_b++;
        end
    end

    task automatic start_a_op(input logic [7:0] o, input logic [AW-1:0] a, input logic [7:0] c,
                              input logic [7:0] d, input logic e_err, input logic e_ccwe,
                              input logic [7:0] e_cc, input int e_lat);
        @(negedge clk);
        op = o; addr = a; cc_in = c; mem_din = d; start_a = 1'b1;
        res_q.push_back('{e_err, e_ccwe, e_cc, e_lat, cyc});
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input string tag);
        int n = 0;
        while (!done_a && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, done_a}, 32'd1);
    endtask

    initial begin
        int n;
        int t0b;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; mem_ack_b = 1'b0;
        op = 8'h00; addr = '0; cc_in = 8'h00; mem_din = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_err", {31'd0, err_a}, 32'd0);
        chk("rst_mem_rd", {31'd0, mem_rd_a}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we_a}, 32'd0);
        chk("rst_cc_we", {31'd0, cc_we_a}, 32'd0);
        chk("rst_mem_addr", {16'd0, mem_addr_a}, 32'd0);
        chk("rst_mem_dout", {24'd0, mem_dout_a}, 32'd0);
        chk("rst_cc_out", {24'd0, cc_out_a}, 32'd0);
        chk("rst_busy_b", {31'd0, busy_b}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // INC 0x7F -> 0x80, N|V
        bus_q.push_back('{1'b0, 16'h1234, 8'h00});
        bus_q.push_back('{1'b1, 16'h1234, 8'h80});
        start_a_op(8'h89, 16'h1234, 8'h00, 8'h7F, 1'b0, 1'b1, 8'h0A, 4);
        wait_done_a("inc_done");

        // TST started in the IDLE cycle right after DONE; no write
        bus_q.push_back('{1'b0, 16'h2000, 8'h00});
        start_a_op(8'h90, 16'h2000, 8'h01, 8'h00, 1'b0, 1'b1, 8'h05, 3);
        wait_done_a("tst_done");

        // CLR: no read, write of zero
        bus_q.push_back('{1'b1, 16'h3000, 8'h00});
        start_a_op(8'h80, 16'h3000, 8'h0B, 8'hAA, 1'b0, 1'b1, 8'h04, 3);
        wait_done_a("clr_done");

        // NEG 0x01 with ack delayed 5 cycles on both accesses
        ack_delay = 5;
        bus_q.push_back('{1'b0, 16'h4000, 8'h00});
        bus_q.push_back('{1'b1, 16'h4000, 8'hFF});
        start_a_op(8'h86, 16'h4000, 8'h00, 8'h01, 1'b0, 1'b1, 8'h09, 14);
        wait_done_a("neg_done");
        ack_delay = 0;

        // Illegal op: err with done, no bus access
        start_a_op(8'h14, 16'h8000, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1);
        wait_done_a("illegal_done");

        // Timeout on the WAIT_MAX=4 instance, ack held low
        @(negedge clk);
        op = 8'h89; addr = 16'h5000; cc_in = 8'h00; start_b = 1'b1; t0b = cyc;
        @(negedge clk);
        start_b = 1'b0;
        n = 0;
        while (!done_b && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("to_done_seen", {31'd0, done_b}, 32'd1);
        chk("to_latency", cyc - t0b, 5);
        chk("to_err", {31'd0, err_b}, 32'd1);
        chk("to_cc_we", {31'd0, cc_we_b}, 32'd0);
        chk("to_read_cycles", rd_cyc_b, 4);
        @(negedge clk);
        chk("to_busy_after", {31'd0, busy_b}, 32'd0);
        chk("to_no_write", {31'd0, we_seen_b}, 32'd0);

        // start held through busy and DONE, inputs changed mid-op: one INC only
        bus_q.push_back('{1'b0, 16'h0F0F, 8'h00});
        bus_q.push_back('{1'b1, 16'h0F0F, 8'h80});
        @(negedge clk);
        op = 8'h89; addr = 16'h0F0F; cc_in = 8'h00; mem_din = 8'h7F; start_a = 1'b1;
        res_q.push_back('{1'b0, 1'b1, 8'h0A, 4, cyc});
        @(negedge clk);
        op = 8'h14; addr = 16'hDEAD; cc_in = 8'hFF;
        repeat (4) @(negedge clk);
        start_a = 1'b0;
        repeat (8) @(negedge clk);
        chk("busy_single_done", res_q.size(), 0);
        chk("busy_idle_after", {31'd0, busy_a}, 32'd0);

        // Reset during WRITE
        ack_delay = 5;
        bus_q.push_back('{1'b0, 16'h6000, 8'h00});
        start_a_op(8'h89, 16'h6000, 8'h00, 8'h10, 1'b0, 1'b1, 8'h00, 14);
        n = 0;
        while (!mem_we_a && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rstw_reached_write", {31'd0, mem_we_a}, 32'd1);
        rst = 1'b1;
        void'(res_q.pop_back());
        @(posedge clk);
        #1;
        chk("rstw_mem_we", {31'd0, mem_we_a}, 32'd0);
        chk("rstw_busy", {31'd0, busy_a}, 32'd0);
        chk("rstw_done", {31'd0, done_a}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ack_delay = 0;
        repeat (6) @(negedge clk);

        // Recovery after reset: INC 0xFF -> 0x00, Z with C preserved
        bus_q.push_back('{1'b0, 16'h7000, 8'h00});
        bus_q.push_back('{1'b1, 16'h7000, 8'h00});
        start_a_op(8'h8A, 16'h7000, 8'h01, 8'hFF, 1'b0, 1'b1, 8'h05, 4);
        wait_done_a("post_rst_done");

        repeat (5) @(negedge clk);
        chk("bus_q_drained", bus_q.size(), 0);
        chk("res_q_drained", res_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtkcpu_rmw_ctl.md
JTKCPU_RMW_CTL -- requirements
Module: jtkcpu_rmw_ctl

Interface
REQ-001 Parameter: AW, 16, memory address width.
REQ-002 Parameter: WAIT_MAX, 255, maximum cycles without mem_ack in READ or WRITE before the operation aborts.
REQ-003 The block SHALL use a single clock, clk, with reset rst, which is synchronous and active-high.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  request for one read-modify-write; sampled only in IDLE.
REQ-007 op  in  8  ALU opcode for the operation.
REQ-008 addr  in  AW  operand address.
REQ-009 cc_in  in  8  condition codes at the time of start.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 err  out  1  one-cycle pulse, coincident with done, flagging a timeout or illegal-op abort.
REQ-013 mem_addr  out  AW  bus address.
REQ-014 mem_rd  out  1  read strobe.
REQ-015 mem_we  out  1  write strobe.
REQ-016 mem_dout  out  8  write data.
REQ-017 mem_din  in  8  read data; valid when mem_ack is high.
REQ-018 mem_ack  in  1  bus cycle complete.
REQ-019 alu_op, alu_opnd0, alu_cc  out  8 each  ALU inputs.
REQ-020 alu_rslt, alu_cc_out  in  8 each  combinational ALU results.
REQ-021 cc_out  out  8  final condition codes.
REQ-022 cc_we  out  1  one-cycle strobe for cc_out.

Function
REQ-023 Legal ops SHALL be the unary memory ops 0x80-0xA2:
- CLR, COM, NEG, INC, DEC, TST, LSR, ROR, ASR, LSL, ROL.
- Condition-code bit order is C0 V1 Z2 N3 H5.
REQ-024 States SHALL be IDLE, READ, EXEC, WRITE and DONE.
REQ-025 IDLE: on start, latch op, addr and cc_in.
- Legal op other than CLR: go to READ.
- CLR (0x80-0x82): load the data register with 0x00 and go to EXEC; no read is performed.
- Illegal op: go to DONE with err set; no bus access.
REQ-026 READ: drive mem_rd=1 and mem_addr=latched addr.
- On mem_ack: capture mem_din and go to EXEC.
REQ-027 EXEC lasts exactly one cycle.
- Drive alu_op=latched op, alu_opnd0=data register, alu_cc=latched cc.
- Register alu_rslt and alu_cc_out.
- TST (0x90-0x92): go to DONE.
- All other ops: go to WRITE.
REQ-028 WRITE: drive mem_we=1, mem_addr=latched addr, mem_dout=registered result.
- On mem_ack: go to DONE.
REQ-029 DONE lasts one cycle.
- Assert done.
- Assert cc_we with cc_out=registered ALU flags, unless err is set.
- Go to IDLE.
REQ-030 mem_rd and mem_we SHALL never be high together, and SHALL be low outside READ and WRITE.
REQ-031 Wait counter:
- Cleared on entry to READ and WRITE; increments each cycle without mem_ack.
- Reaching WAIT_MAX without ack: go to DONE with err=1, cc_we=0, and write nothing further.
REQ-032 start while busy SHALL be ignored and not queued.
- start in the DONE cycle is also ignored.
- start in IDLE the cycle after DONE is accepted.
REQ-033 Latency with mem_ack always high:
- done occurs 4 cycles after start is sampled (READ, EXEC, WRITE, DONE).
- TST and CLR: 3 cycles.
REQ-034 Inputs op, addr and cc_in SHALL be ignored after capture; changes mid-operation have no effect.

Reset
REQ-035 While rst is high on a clock edge, the block SHALL:
- Go to IDLE.
- Set busy, done, err, mem_rd, mem_we and cc_we to 0.
- Clear mem_addr, mem_dout, cc_out, the data and result registers and the wait counter to 0.
REQ-036 A reset asserted mid-operation SHALL abort the operation with no done pulse.
- Bus strobes are low from the first edge with rst high.

Verification
REQ-037 INC (0x89), addr 0x1234, cc_in 0x00, mem_din 0x7F, ack always high.
- Expected: read at 0x1234, then write of 0x80 to 0x1234.
- cc_out 0x0A; done 4 cycles after start.
REQ-038 TST (0x90), mem_din 0x00, cc_in 0x01.
- Expected: no mem_we; cc_out 0x05; done after 3 cycles.
REQ-039 CLR (0x80), cc_in 0x0B.
- Expected: no mem_rd; write of 0x00; cc_out 0x04.
REQ-040 NEG (0x86), mem_din 0x01, mem_ack delayed 5 cycles in both READ and WRITE.
- Expected: write of 0xFF; cc_out 0x09; strobes held until ack; done 14 cycles after start.
REQ-041 Timeout: mem_ack held low and WAIT_MAX=4.
- Expected: err and done pulse after 4 cycles in READ; cc_we=0; no mem_we.
- Illegal op 0x14 also produces err and done with no bus access.
REQ-042 Reset and start handling:
- rst asserted during WRITE: mem_we low on the next edge; no done; busy=0.
- A second start during busy is ignored; exactly one done is produced.
